uart_frame_ctrl: RTL and testbench

Frame controller that sits behind the single-byte UART receiver and sequences its byte stream into command frames. It consumes the receiver's one-cycle byte-done strobe and parallel byte. It parses the frame HEADER, ADDR, LEN, PAYLOAD[LEN], CSUM and buffers the payload internally. Only after the checksum passes does it commit the payload as a burst of register writes. It also reports length, checksum, timeout and overrun faults to the system.

---
 rtl/uart_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
// Sequences the byte stream of a single-byte UART receiver into command
// frames: HEADER, ADDR, LEN, PAYLOAD[LEN], CSUM. Payload bytes are buffered and
// committed as a burst of register writes only after the checksum matches.
// Length, checksum, inter-byte timeout and commit-overrun faults are reported.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx_valid   one-cycle strobe: rx_data holds a new byte
//   rx_data    received byte
//   wr_en      register write strobe (one write per cycle)
//   wr_addr    write address (base + index, 8-bit wrap)
//   wr_data    write data
//   frame_done one-cycle pulse after the last write of a good frame
//   frame_err  one-cycle pulse on a fault
//   err_code   fault cause, held until the next fault: 1=LEN, 2=CSUM, 3=timeout
//   overrun    one-cycle pulse when a byte arrives during COMMIT and is dropped
//   busy       high whenever the controller is not idle
module uart_frame_ctrl #(
   parameter logic [7:0] HEADER  = 8'h55,
   parameter int         MAX_LEN = 16,
   parameter int         TIMEOUT = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       wr_en,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       frame_done,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       overrun,
   output logic       busy
);

   localparam int         AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int         CW       = $clog2(TIMEOUT + 1);
   localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_COMMIT
   } state_t;

   state_t          state;
   logic [7:0]      base;
   logic [7:0]      len;
   logic [7:0]      idx;
   logic [7:0]      sum;
   logic [CW-1:0]   tcnt;
   logic [7:0]      mem [MAX_LEN];

   logic in_frame;
   logic tmo;
   logic mem_we;

   // The timeout only runs while a frame is being received; a byte arriving
   // on the terminal-count cycle takes priority over the timeout.
   assign in_frame = (state == S_ADDR) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CSUM);
   assign tmo      = in_frame && !rx_valid && (tcnt == CW'(TIMEOUT - 1));
   assign mem_we   = (state == S_DATA) && rx_valid;

   // NOTE: the payload buffer has no reset; its contents are only read after
   // being written by the current frame, so clearing it would buy nothing.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx[AW-1:0]] <= rx_data;
   end

   // NOTE: all state and registered outputs use non-blocking assignments so
   // every read in this block sees the value from before the clock edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         base       <= '0;
         len        <= '0;
         idx        <= '0;
         sum        <= '0;
         tcnt       <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_code   <= '0;
         overrun    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;

         // Every state entry inside a frame happens on a byte, so clearing on
         // rx_valid also covers the clear-on-entry rule.
         if (rx_valid || !in_frame || tmo) tcnt <= '0;
         else                              tcnt <= tcnt + 1'b1;

         if (tmo) begin
            frame_err <= 1'b1;
            err_code  <= 2'd3;
            state     <= S_IDLE;
            busy      <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (rx_valid && rx_data == HEADER) begin
                     state <= S_ADDR;
                     busy  <= 1'b1;
                  end
               end
               S_ADDR: begin
                  if (rx_valid) begin
                     base  <= rx_data;
                     sum   <= rx_data;
                     state <= S_LEN;
                  end
               end
               S_LEN: begin
                  if (rx_valid) begin
                     if (rx_data == 8'd0 || rx_data > MAX_LEN8) begin
                        frame_err <= 1'b1;
                        err_code  <= 2'd1;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                     end else begin
                        len   <= rx_data;
                        sum   <= sum + rx_data;
                        idx   <= '0;
                        state <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (rx_valid) begin
                     sum <= sum + rx_data;
                     if (idx == len - 8'd1) state <= S_CSUM;
                     else                   idx   <= idx + 8'd1;
                  end
               end
               S_CSUM: begin
                  if (rx_valid) begin
                     if (rx_data == sum) begin
                        idx   <= '0;
                        state <= S_COMMIT;
                     end else begin
                        frame_err <= 1'b1;
                        err_code  <= 2'd2;
                        state     <= S_IDLE;
                        busy      <= 1'b0;
                     end
                  end
               end
               S_COMMIT: begin
                  // Bytes arriving while committing are dropped, not parsed.
                  overrun <= rx_valid;
                  if (idx == len) begin
                     frame_done <= 1'b1;
                     state      <= S_IDLE;
                     busy       <= 1'b0;
                  end else begin
                     wr_en   <= 1'b1;
                     wr_addr <= base + idx;
                     wr_data <= mem[idx[AW-1:0]];
                     idx     <= idx + 8'd1;
                  end
               end
               default: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Testbench for uart_frame_ctrl: a stream-level reference model turns every
// byte fed to the DUT into expected writes and frame events, which a separate
// monitor pops and compares whenever the DUT pulses an output.
module tb_uart_frame_ctrl;

   localparam logic [7:0] HDR  = 8'h55;
   localparam int         MAXL = 16;
   localparam int         TMO  = 50;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       frame_done;
   logic       frame_err;
   logic [1:0] err_code;
   logic       overrun;
   logic       busy;

   uart_frame_ctrl #(.HEADER(HDR), .MAX_LEN(MAXL), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .frame_done(frame_done), .frame_err(frame_err), .err_code(err_code),
      .overrun(overrun), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard ----------------
   typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
   wr_t        wr_q[$];
   int         evt_q[$];     // 0 = frame_done, 1..3 = frame_err with that code
   logic [7:0] cur[$];       // bytes of the frame currently being received
   logic [7:0] pl[$];        // payload for the next frame sent
   int         last_len;
   int         ovr_exp = 0;
   int         ovr_seen = 0;
   bit         prev_wr = 0;
   wr_t        w_exp;
   int         e_exp;

   // Reference model: the frame is the list of bytes from HEADER onwards;
   // its fate is decided once the length byte, or the checksum byte, is in.
   task automatic model_byte(input logic [7:0] b);
      int s;
      int n;
      last_len = 0;
      if (cur.size() == 0) begin
         if (b == HDR) cur.push_back(b);
         return;
      end
      cur.push_back(b);
      n = cur.size();
      if (n == 3 && (int'(b) == 0 || int'(b) > MAXL)) begin
         evt_q.push_back(1);
         cur.delete();
         return;
      end
      if (n >= 4 && n == 4 + int'(cur[2])) begin
         s = 0;
         for (int i = 1; i <= n - 2; i++) s += int'(cur[i]);
         if (cur[n-1] == s[7:0]) begin
            for (int i = 0; i < int'(cur[2]); i++) begin
               wr_t w;
               w.addr = 8'((int'(cur[1]) + i) % 256);
               w.data = cur[3+i];
               wr_q.push_back(w);
            end
            evt_q.push_back(0);
            last_len = int'(cur[2]);
         end else begin
            evt_q.push_back(2);
         end
         cur.delete();
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_en) begin
            if (wr_q.size() == 0) check("unexpected_wr", 1, 0);
            else begin
               w_exp = wr_q.pop_front();
               check("wr_addr", wr_addr, w_exp.addr);
               check("wr_data", wr_data, w_exp.data);
            end
         end
         if (frame_done) begin
            if (evt_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
               e_exp = evt_q.pop_front();
               check("done_event", 0, e_exp);
               check("done_after_last_wr", prev_wr, 1);
               check("done_without_wr", wr_en, 0);
            end
         end
         if (frame_err) begin
            if (evt_q.size() == 0) check("unexpected_err", 1, 0);
            else begin
               e_exp = evt_q.pop_front();
               check("err_code", err_code, e_exp);
            end
         end
         if (overrun) ovr_seen++;
         prev_wr = wr_en;
      end else begin
         prev_wr = 0;
      end
   end

   // ---------------- stimulus helpers (all start and end at a negedge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   // Feed the model, drive the byte, and if a commit started let it finish.
   task automatic send(input logic [7:0] b, input bit no_wait);
      model_byte(b);
      drive(b);
      if (!no_wait && last_len > 0) idle(last_len + 1);
   endtask

   task automatic gap();
      idle($urandom_range(0, 3));
   endtask

   bit busy_before;

   task automatic frame(input logic [7:0] addr, input logic [7:0] n,
                        input bit bad_sum, input bit no_wait);
      logic [7:0] s;
      s = addr + n;
      send(HDR, 0); gap();
      send(addr, 0); gap();
      send(n, 0);
      if (int'(n) == 0 || int'(n) > MAXL) return;
      for (int i = 0; i < int'(n); i++) begin
         gap();
         send(pl[i], 0);
         s = s + pl[i];
      end
      gap();
      busy_before = busy;
      send(bad_sum ? (s ^ 8'h01) : s, no_wait);
   endtask

   task automatic rand_payload(input int n);
      pl.delete();
      for (int i = 0; i < n; i++) pl.push_back(8'($urandom));
   endtask

   task automatic garbage();
      logic [7:0] g;
      repeat ($urandom_range(0, 2)) begin
         g = 8'($urandom);
         if (g == HDR) g = 8'h00;
         send(g, 0);
         gap();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   int k;
   int r;
   int n;

   initial begin
      // ---- reset state ----
      idle(2);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_frame_done", frame_done, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_code", err_code, 0);
      check("rst_overrun", overrun, 0);
      check("rst_busy", busy, 0);
      rst = 1'b0;
      idle(2);

      // ---- good frame 55 10 03 AA BB CC 44 ----
      pl = '{8'hAA, 8'hBB, 8'hCC};
      frame(8'h10, 8'd3, 0, 0);
      check("good_busy_before_csum", busy_before, 1);
      check("good_idle_after", busy, 0);

      // ---- address wrap, then a maximum-length frame ----
      pl = '{8'h01, 8'h02};
      frame(8'hFF, 8'd2, 0, 0);
      rand_payload(MAXL);
      frame(8'($urandom), 8'(MAXL), 0, 0);

      // ---- bad lengths, then a header is accepted again ----
      frame(8'h10, 8'h00, 0, 0);
      check("badlen0_idle", busy, 0);
      frame(8'h10, 8'h11, 0, 0);
      check("badlen17_code", err_code, 1);
      pl = '{8'h5A};
      frame(8'h30, 8'd1, 0, 0);

      // ---- bad checksum 55 10 03 AA BB CC 45 ----
      pl = '{8'hAA, 8'hBB, 8'hCC};
      frame(8'h10, 8'd3, 1, 0);
      check("badsum_busy_before", busy_before, 1);
      check("badsum_busy_falls", busy, 0);

      // ---- garbage then timeout: 00 13 55 20 then silence ----
      send(8'h00, 0); send(8'h13, 0); send(HDR, 0); send(8'h20, 0);
      check("garbage_ignored_busy", busy, 1);
      evt_q.push_back(3);
      cur.delete();
      k = 0;
      while (!frame_err && k < 3 * TMO) begin
         @(negedge clk);
         k++;
      end
      check("timeout_cycles", k, TMO);
      check("timeout_busy", busy, 0);

      // ---- strobe on the terminal-count cycle wins over the timeout ----
      send(HDR, 0); send(8'h20, 0);
      idle(TMO - 1);
      send(8'h01, 0);
      check("terminal_strobe_no_err", frame_err, 0);
      send(8'h5A, 0);
      send(8'h7B, 0);                     // 20+01+5A
      check("err_code_held", err_code, 3);

      // ---- reset during DATA ----
      send(HDR, 0); send(8'h10, 0); send(8'h05, 0); send(8'hAA, 0); send(8'hBB, 0);
      rst = 1'b1;
      cur.delete();
      idle(2);
      check("rstdata_busy", busy, 0);
      check("rstdata_wr_en", wr_en, 0);
      rst = 1'b0;
      idle(2);
      rand_payload(4);
      frame(8'h40, 8'd4, 0, 0);

      // ---- reset during COMMIT: 3 of 8 writes happen, the rest never do ----
      rand_payload(8);
      frame(8'hC0, 8'd8, 0, 1);
      idle(3);
      #2 rst = 1'b1;
      #1;
      check("rstcommit_wr_en", wr_en, 0);
      check("rstcommit_busy", busy, 0);
      check("rstcommit_writes_left", wr_q.size(), 5);
      check("rstcommit_events_left", evt_q.size(), 1);
      wr_q.delete();
      evt_q.delete();
      idle(2);
      rst = 1'b0;
      idle(5);
      pl = '{8'hAA, 8'hBB, 8'hCC};
      frame(8'h10, 8'd3, 0, 0);

      // ---- overrun during COMMIT ----
      rand_payload(4);
      frame(8'h80, 8'd4, 0, 1);
      drive(HDR);                         // dropped, not parsed
      ovr_exp++;
      check("overrun_pulse", overrun, 1);
      idle(4);
      check("overrun_no_restart", busy, 0);

      // ---- randomized frames ----
      for (int it = 0; it < 30; it++) begin
         garbage();
         r = $urandom_range(0, 9);
         if (r < 7) begin
            n = $urandom_range(1, MAXL);
            rand_payload(n);
            frame(8'($urandom), 8'(n), 0, 0);
         end else if (r == 7) begin
            n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXL + 1, 255);
            frame(8'($urandom), 8'(n), 0, 0);
         end else begin
            n = $urandom_range(1, MAXL);
            rand_payload(n);
            frame(8'($urandom), 8'(n), 1, 0);
         end
         gap();
      end

      idle(5);
      check("end_writes_pending", wr_q.size(), 0);
      check("end_events_pending", evt_q.size(), 0);
      check("end_overrun_count", ovr_seen, ovr_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
